// File: rtl/noc_pkg.sv
// Shared NoC definitions: port encodings, flit types, and the output-allocator state enum.
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int FLIT_WIDTH = 32;

  localparam int IDX_INJ   = 0;
  localparam int IDX_NORTH = 1;
  localparam int IDX_SOUTH = 2;
  localparam int IDX_WEST  = 3;
  localparam int IDX_EAST  = 4;

  localparam logic [2:0] PORT_INJ   = 3'b000;
  localparam logic [2:0] PORT_NORTH = 3'b001;
  localparam logic [2:0] PORT_SOUTH = 3'b010;
  localparam logic [2:0] PORT_WEST  = 3'b011;
  localparam logic [2:0] PORT_EAST  = 3'b100;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_GRANTED = 2'd2
  } alloc_state_e;

  // Requester index following i, wrapping 4 -> 0.
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == 3'd4) ? 3'd0 : i + 3'd1;
  endfunction

endpackage

// File: rtl/output_port_allocator_rr_arbiter5.sv
// Combinational 5-way round-robin picker; search starts at ptr_i and wraps.
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic [4:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [4:0] gnt_o,
  output logic [2:0] idx_o,
  output logic       any_o
);

  logic [2:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = ptr_i;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// One router output port: packet-level ownership by round-robin, per-flit switch
// grants gated by downstream credits, and crossbar select/enable for the owner.
module output_port_allocator
  import noc_pkg::*;
#(
  parameter int PORT_ID    = 1,
  parameter int BUFF_DEPTH = 8,
  parameter int XBAR_DLY   = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] vc_req_i,
  input  logic [4:0] sw_req_i,
  input  logic [4:0] release_i,
  input  logic       credit_in_i,
  output logic [4:0] vc_gnt_o,
  output logic [4:0] sw_gnt_o,
  output logic       usage_o,
  output logic [7:0] buff_count_o,
  output logic [2:0] xbar_sel_o,
  output logic       xbar_en_o,
  output logic       credit_err_o
);

  localparam logic [1:0] S_FREE    = ST_FREE;
  localparam logic [1:0] S_OWNED   = ST_OWNED;
  localparam logic [1:0] S_GRANTED = ST_GRANTED;

  // PORT_ID 0 is the injection port, which may legally send back to itself.
  localparam logic [4:0] REQ_MASK = (PORT_ID == 0) ? 5'b11111 : ~(5'b00001 << PORT_ID);
  localparam logic [7:0] DEPTH    = 8'(BUFF_DEPTH);

  function automatic logic [7:0] credit_next(input logic [7:0] c, input logic inc,
                                             input logic dec);
    if (dec && !inc)                    return c - 8'd1;
    else if (inc && !dec && c < DEPTH)  return c + 8'd1;
    else                                return c;
  endfunction

  function automatic logic credit_ovf(input logic [7:0] c, input logic inc, input logic dec);
    return inc && !dec && (c >= DEPTH);
  endfunction

  logic [1:0]          state_q, state_d;
  logic [2:0]          owner_q, owner_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [4:0]          vc_gnt_q, vc_gnt_d;
  logic [4:0]          sw_gnt_q, sw_gnt_d;
  logic [7:0]          buff_q, buff_d;
  logic                err_q, err_d;
  logic [XBAR_DLY-1:0] xbar_dly_q;
  logic                sw_take;

  logic [4:0] arb_gnt;
  logic [2:0] arb_idx;
  logic       arb_any;

  rr_arbiter5 u_arb (
    .req_i (vc_req_i & REQ_MASK),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    vc_gnt_d = '0;
    sw_gnt_d = '0;
    sw_take  = 1'b0;
    case (state_q)
      S_FREE: begin
        if (arb_any) begin
          vc_gnt_d = arb_gnt;
          owner_d  = arb_idx;
          rr_ptr_d = next_idx(arb_idx);
          state_d  = S_OWNED;
        end
      end
      S_OWNED: begin
        // Tail release wins over a same-cycle flit request.
        if (release_i[owner_q]) begin
          state_d = S_FREE;
        end else if (sw_req_i[owner_q] && (buff_q != 8'd0)) begin
          sw_gnt_d[owner_q] = 1'b1;
          sw_take           = 1'b1;
          state_d           = S_GRANTED;
        end
      end
      S_GRANTED: state_d = release_i[owner_q] ? S_FREE : S_OWNED;
      default:   state_d = S_FREE;
    endcase
  end

  always_comb begin
    buff_d = credit_next(buff_q, credit_in_i, sw_take);
    err_d  = err_q | credit_ovf(buff_q, credit_in_i, sw_take);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_FREE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      vc_gnt_q   <= '0;
      sw_gnt_q   <= '0;
      buff_q     <= DEPTH;
      err_q      <= 1'b0;
      xbar_dly_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      vc_gnt_q      <= vc_gnt_d;
      sw_gnt_q      <= sw_gnt_d;
      buff_q        <= buff_d;
      err_q         <= err_d;
      // Crossbar enable trails the switch grant by XBAR_DLY cycles.
      xbar_dly_q[0] <= |sw_gnt_q;
      for (int i = 1; i < XBAR_DLY; i++) xbar_dly_q[i] <= xbar_dly_q[i-1];
    end
  end

  assign vc_gnt_o     = vc_gnt_q;
  assign sw_gnt_o     = sw_gnt_q;
  assign usage_o      = (state_q != S_FREE);
  assign buff_count_o = buff_q;
  assign xbar_sel_o   = owner_q;
  assign xbar_en_o    = xbar_dly_q[XBAR_DLY-1];
  assign credit_err_o = err_q;

endmodule

// File: doc/output_port_allocator.md
# output_port_allocator

Per-output-port allocator that shares one router output (N, S, E, W or local) among the five input-port node controllers. It grants exclusive packet-level ownership of the port (VC allocation) by round-robin, issues per-flit switch grants only while downstream buffer credits remain, and drives the crossbar select and enable for the owning input. One instance sits at each output port, between the node controllers' `*_vc_arb_req`/`*_sw_arb_req` lines and the crossbar.

## Interface
- `PORT_ID`, 1: requester index of this output's own direction (0=INJ, 1=NORTH, 2=SOUTH, 3=WEST, 4=EAST); that requester is masked (no U-turn). 0 disables masking.
- `BUFF_DEPTH`, 8: downstream input-buffer depth; the credit reset value.
- `XBAR_DLY`, 2: cycles from `sw_gnt` pulse to `xbar_en`.

- `Clk` in 1: clock, rising edge.
- `Rst` in 1: reset, synchronous and active-low.
- `vc_req` in 5: level requests for port ownership, indexed by requester.
- `sw_req` in 5: level per-flit switch requests.
- `release` in 5: one-cycle pulse from the requester whose tail flit has left.
- `credit_in` in 1: one-cycle pulse, downstream freed one slot.
- `vc_gnt` out 5: registered one-hot ownership grant pulse.
- `sw_gnt` out 5: registered one-hot switch grant pulse.
- `usage` out 1: port currently owned.
- `buff_count` out 8: available downstream credits.
- `xbar_sel` out 3: owner index, crossbar mux select.
- `xbar_en` out 1: crossbar output valid.
- `credit_err` out 1: sticky, set on credit overflow.

## Operation
- FSM states FREE, OWNED, GRANTED.
- FREE: the masked `vc_req` is arbitered round-robin from `rr_ptr`. A winner w causes `vc_gnt[w]`=1 for one cycle, `owner`=w, `usage`=1, `rr_ptr`=(w+1) mod 5, and a transition to OWNED. With no request, the FSM stays in FREE.
- OWNED: `release[owner]` returns the FSM to FREE (`usage`=0); release has precedence over `sw_req` in the same cycle and no `sw_gnt` is issued. Otherwise, `sw_req[owner]` && `buff_count`>0 pulses `sw_gnt[owner]`, decrements credit, and moves to GRANTED.
- GRANTED: lasts exactly one cycle, which blocks the requester's re-request while the controller is leaving SW_ARB. It then returns to OWNED. `release[owner]` in this state goes directly to FREE.
- `release` and `sw_req` from non-owners are ignored. `vc_req` while OWNED/GRANTED is held pending and is not granted.
- Credits: -1 per `sw_gnt`, +1 per `credit_in`. Both in the same cycle give a net 0. `credit_in` at `BUFF_DEPTH` saturates and sets `credit_err`. `buff_count` never wraps below 0.
- `xbar_sel` holds `owner` from `vc_gnt` until the next grant. It is unchanged while FREE.
- `xbar_en` is `sw_gnt` delayed by a `XBAR_DLY`-stage shift register. The pipeline drains normally after release.

## Timing
- Reset values: FSM FREE, `vc_gnt`=0, `sw_gnt`=0, `usage`=0, `buff_count`=`BUFF_DEPTH`, `xbar_sel`=0, `xbar_en`=0, `credit_err`=0, `rr_ptr`=0, delay line cleared.
- Reset mid-packet drops ownership and restores full credits on the next edge.
- `vc_gnt` goes high in cycle t+1 for `vc_req` sampled at edge t.
- `sw_gnt` goes high in cycle t+1 for `sw_req` sampled at t in OWNED.
- `xbar_en` goes high at `sw_gnt` + `XBAR_DLY`.
- Minimum spacing between `sw_gnt` pulses to one owner is 2 cycles.
- Minimum turnaround from `release` to the next `vc_gnt` is 2 cycles.

## Structure
- The shared package `noc_pkg` holds the port encodings (INJ=0..EAST=4 index, 3'b000..3'b100 codes), the flit type constants HEAD/BODY/TAIL, `FLIT_WIDTH`, and the FSM state enum.
- Sub-module `rr_arbiter5`: 5-way one-hot round-robin picker (req, ptr → gnt, winner index). It is purely combinational. The pointer register lives in the parent.

## Test plan
- Reset with all inputs 0 → `buff_count`=8, `usage`=0, all grants 0; holding `Rst` low while `vc_req`=5'b00010 gives no grant.
- `vc_req`=5'b00010 (PORT_ID=3) → `vc_gnt`=5'b00010 next cycle, `usage`=1, `xbar_sel`=1. `vc_req`=5'b01000 is never granted.
- `vc_req`=5'b10101 held, each owner releasing after one flit → ownership order 0, 2, 4, 0.
- Owner holds `sw_req` with no `credit_in` → 8 `sw_gnt` pulses every 2 cycles, `buff_count` reaches 0, and no further grants. One `credit_in` → exactly one more `sw_gnt`.
- `release[owner]` and `sw_req[owner]` in the same cycle → no `sw_gnt`, FREE next cycle. `sw_gnt` and `credit_in` in the same cycle → `buff_count` unchanged.
- `credit_in` at `buff_count`=8 → `buff_count` stays 8, `credit_err`=1 until reset. `xbar_en` pulses exactly 2 cycles after each `sw_gnt`.
